// File: rtl/gaussian_pkg.sv
// -----------------------------------------------------------------------------
// gaussian_pkg
// Shared constants for the 3x3 Gaussian blur: kernel weights, the
// normalisation shift, the rounding bias and the accumulator width helper.
// No ports.
// -----------------------------------------------------------------------------
package gaussian_pkg;

  // Kernel [1 2 1; 2 4 2; 1 2 1] / 16
  localparam int W_CORNER     = 1;
  localparam int W_EDGE       = 2;
  localparam int W_CENTRE     = 4;
  localparam int KERNEL_SHIFT = 4;
  localparam int ROUND_BIAS   = 8;

  // Weights are powers of two, so every product is a left shift
  localparam int SH_CORNER = $clog2(W_CORNER);
  localparam int SH_EDGE   = $clog2(W_EDGE);
  localparam int SH_CENTRE = $clog2(W_CENTRE);

  // Sum of weights is 16, so 4 extra bits hold the worst-case sum
  function automatic int ACC_W(input int pixel_bit_width);
    return pixel_bit_width + 4;
  endfunction

endpackage

// File: rtl/gaussian_filter_3x3_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One buffered image row: DEPTH entries of WIDTH bits, addressed by column.
// The read port is combinational and the write lands on the clock edge, so a
// read of the address being written in the same cycle returns the old data.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   addr   in   column address (shared by read and write)
//   wdata  in   data to store
//   rdata  out  data currently stored at addr (pre-write value)
// -----------------------------------------------------------------------------
module line_buffer #(
  parameter int DEPTH  = 20,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] idx;

  assign idx   = addr[IDX_W-1:0];
  assign rdata = mem[idx];

  // Row storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: rtl/gaussian_filter_3x3.sv
// -----------------------------------------------------------------------------
// gaussian_filter_3x3
// Streaming 3x3 Gaussian blur over one IMG_ROWS x IMG_COLS raster frame,
// emitting the (IMG_ROWS-2) x (IMG_COLS-2) valid region, row-major, one beat
// after the pixel that completes each window.
// Build option: define GAUSSIAN_ROUND_EN for round-half-up ((acc+8)>>4);
// otherwise the result is truncated (acc>>4).
// Ports:
//   clk               in   clock, rising edge
//   reset             in   synchronous, active-high
//   pixel_in_TDATA    in   input pixel
//   pixel_in_TVALID   in   input beat valid
//   pixel_in_TREADY   out  input beat accepted when high
//   pixel_out_TDATA   out  blurred pixel (registered)
//   pixel_out_TVALID  out  output beat valid (registered)
//   pixel_out_TREADY  in   downstream accepts output beat
// -----------------------------------------------------------------------------
module gaussian_filter_3x3
  import gaussian_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int IMG_ROWS         = 20,
  parameter int IMG_COLS         = 20,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
  input  logic                       pixel_in_TVALID,
  output logic                       pixel_in_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
  output logic                       pixel_out_TVALID,
  input  logic                       pixel_out_TREADY
);

  localparam int PW = PIXEL_BIT_WIDTH;
  localparam int AW = ACC_W(PIXEL_BIT_WIDTH);
  localparam int RB = IMG_ROW_BITWIDTH;
  localparam int CB = IMG_COL_BITWIDTH;

  logic [RB-1:0] row;
  logic [CB-1:0] col;
  logic          accept;
  logic          emit;
  logic          last_col;
  logic          last_row;

  // Line-buffer read data: rows r-2 (top) and r-1 (middle) at column col
  logic [PW-1:0] top_rd;
  logic [PW-1:0] mid_rd;

  // Two most recent window columns: a = left, b = middle; the right column
  // is the live {top_rd, mid_rd, pixel_in_TDATA}
  logic [PW-1:0] a_top, a_mid, a_bot;
  logic [PW-1:0] b_top, b_mid, b_bot;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_adj;
  logic [PW-1:0] result;

  assign pixel_in_TREADY = !pixel_out_TVALID || pixel_out_TREADY;
  assign accept          = pixel_in_TVALID && pixel_in_TREADY;
  assign last_col        = (col == CB'(IMG_COLS - 1));
  assign last_row        = (row == RB'(IMG_ROWS - 1));
  // Requiring c>=2 keeps windows from straddling the previous row's tail
  assign emit            = (row >= RB'(2)) && (col >= CB'(2));

  // Middle row buffer is written with the new pixel; top buffer inherits the
  // old middle value, so the pair always holds rows r-2 and r-1
  line_buffer #(.DEPTH(IMG_COLS), .WIDTH(PW), .ADDR_W(CB)) u_line_buf1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (pixel_in_TDATA),
    .rdata (mid_rd)
  );

  line_buffer #(.DEPTH(IMG_COLS), .WIDTH(PW), .ADDR_W(CB)) u_line_buf0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (mid_rd),
    .rdata (top_rd)
  );

  // Weighted sum of the window that includes the pixel being accepted now
  always_comb begin
    acc = (AW'(a_top)          << SH_CORNER) + (AW'(b_top) << SH_EDGE)   + (AW'(top_rd) << SH_CORNER)
        + (AW'(a_mid)          << SH_EDGE)   + (AW'(b_mid) << SH_CENTRE) + (AW'(mid_rd) << SH_EDGE)
        + (AW'(a_bot)          << SH_CORNER) + (AW'(b_bot) << SH_EDGE)
        + (AW'(pixel_in_TDATA) << SH_CORNER);
`ifdef GAUSSIAN_ROUND_EN
    acc_adj = acc + AW'(ROUND_BIAS);
`else
    acc_adj = acc;
`endif
    result = PW'(acc_adj >> KERNEL_SHIFT);
  end

  // Window column shift on every accepted pixel; no reset needed (data path)
  always_ff @(posedge clk) begin
    if (accept) begin
      a_top <= b_top;
      a_mid <= b_mid;
      a_bot <= b_bot;
      b_top <= top_rd;
      b_mid <= mid_rd;
      b_bot <= pixel_in_TDATA;
    end
  end

  // Raster counters and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      row              <= RB'(0);
      col              <= CB'(0);
      pixel_out_TVALID <= 1'b0;
      pixel_out_TDATA  <= PW'(0);
    end else begin
      if (accept) begin
        if (last_col) begin
          col <= CB'(0);
          row <= last_row ? RB'(0) : row + RB'(1);
        end else begin
          col <= col + CB'(1);
        end
      end
      // A new emit wins over a drain in the same cycle, keeping TVALID high
      if (accept && emit) begin
        pixel_out_TVALID <= 1'b1;
        pixel_out_TDATA  <= result;
      end else if (pixel_out_TREADY) begin
        pixel_out_TVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_filter_3x3.sv
module tb_gaussian_filter_3x3;

  localparam int PW   = 12;
  localparam int R    = 20;
  localparam int C    = 20;
  localparam int NOUT = (R - 2) * (C - 2);
`ifdef GAUSSIAN_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  gaussian_filter_3x3 dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_in_TDATA   (in_data),
    .pixel_in_TVALID  (in_valid),
    .pixel_in_TREADY  (in_ready),
    .pixel_out_TDATA  (out_data),
    .pixel_out_TVALID (out_valid),
    .pixel_out_TREADY (out_ready)
  );

  // pat: 0 constant, 1 impulse at (5,5), 2 ramp r*20+c, 3 random
  // period: ready high 1 of N cycles; 0 = random ready and random input gaps
  // exp_nz / exp_peak: -1 = not checked
  typedef struct {
    int pat;
    int val;
    int period;
    int exp_cnt;
    int exp_nz;
    int exp_peak;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int img [R][C];
  int pix_q [$];
  int exp_q [$];
  int got_q [$];

  task automatic check(input string name, input int idx, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, got, exp);
    end
  endtask

  task automatic fill(input int pat, input int val);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        case (pat)
          0:       img[r][c] = val;
          1:       img[r][c] = (r == 5 && c == 5) ? val : 0;
          2:       img[r][c] = r * 20 + c;
          default: img[r][c] = int'($urandom_range(0, 4095));
        endcase
  endtask

  // Reference: blur every interior pixel of img and append to the queues
  task automatic model_frame();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        pix_q.push_back(img[r][c]);
    for (int r = 1; r < R - 1; r++)
      for (int c = 1; c < C - 1; c++) begin
        int acc = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            acc += img[r+dr][c+dc] * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
        exp_q.push_back(RND ? (acc + 8) / 16 : acc / 16);
      end
  endtask

  task automatic clear_q();
    pix_q.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  // Drive pix_q, collect outputs; stop_after>0 stops after that many accepts
  task automatic stream(input int period, input int stop_after);
    int idx = 0;
    int cyc = 0;
    bit hold = 1'b0;
    int held = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (hold) begin
        check("hold_valid", cyc, int'(out_valid), 1);
        check("hold_data", cyc, int'(out_data), held);
      end
      out_ready = (period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % period) == 0);
      if (idx < pix_q.size() && (stop_after == 0 || idx < stop_after))
        in_valid = (period == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      else
        in_valid = 1'b0;
      in_data = in_valid ? PW'(pix_q[idx]) : PW'(0);
      #1;
      check("in_ready", cyc, int'(in_ready), int'(!out_valid || out_ready));
      if (out_valid && out_ready) got_q.push_back(int'(out_data));
      hold = out_valid && !out_ready;
      held = int'(out_data);
      if (in_valid && in_ready) idx++;
      cyc++;
      if (stop_after > 0) done = (idx >= stop_after);
      else                done = (idx >= pix_q.size()) && (got_q.size() >= exp_q.size());
      if (cyc > 20000) begin
        check("timeout", cyc, got_q.size(), exp_q.size());
        done = 1'b1;
      end
    end
    if (stop_after == 0) begin
      // A few idle cycles to catch any surplus output beats
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid) got_q.push_back(int'(out_data));
      end
    end
  endtask

  task automatic verify(input string name, input int exp_cnt, input int exp_nz, input int exp_peak);
    int nz = 0;
    int peak = 0;
    int n;
    check({name, "_count"}, 0, got_q.size(), exp_cnt);
    check({name, "_model_count"}, 0, exp_q.size(), exp_cnt);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_pix"}, i, got_q[i], exp_q[i]);
    foreach (got_q[i]) begin
      if (got_q[i] != 0) nz++;
      if (got_q[i] > peak) peak = got_q[i];
    end
    if (exp_nz >= 0)   check({name, "_nonzero"}, 0, nz, exp_nz);
    if (exp_peak >= 0) check({name, "_peak"}, 0, peak, exp_peak);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{0, 100,  1, NOUT, NOUT, 100};
    tbl[1] = '{1, 1600, 1, NOUT, 9, 400};
    tbl[2] = '{1, 2,    1, NOUT, RND, RND};
    tbl[3] = '{2, 0,    3, NOUT, NOUT, 378};
    tbl[4] = '{3, 0,    1, NOUT, -1, -1};
    tbl[5] = '{3, 0,    0, NOUT, -1, -1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 0, int'(out_valid), 0);
    check("rst_data", 0, int'(out_data), 0);
    check("rst_ready", 0, int'(in_ready), 1);
    reset = 1'b0;

    for (int t = 0; t < 6; t++) begin
      clear_q();
      fill(tbl[t].pat, tbl[t].val);
      model_frame();
      stream(tbl[t].period, 0);
      verify($sformatf("vec%0d", t), tbl[t].exp_cnt, tbl[t].exp_nz, tbl[t].exp_peak);
    end

    // Reset mid-frame after 150 accepted pixels
    clear_q();
    fill(2, 0);
    model_frame();
    stream(1, 150);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_valid", 0, int'(out_valid), 0);
    clear_q();
    fill(0, 55);
    model_frame();
    stream(1, 0);
    verify("after_rst", NOUT, NOUT, 55);

    // Back-to-back frames with no gap
    clear_q();
    fill(0, 0);
    model_frame();
    fill(0, 4095);
    model_frame();
    stream(1, 0);
    verify("b2b", 2 * NOUT, NOUT, 4095);
    for (int i = 0; i < NOUT && i < got_q.size(); i++)
      if (got_q[i] != 0) check("b2b_first_zero", i, got_q[i], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
